// File: rtl/regpair_sequencer.sv
// regpair_sequencer: drives the AVR register file's single write port for
// 16-bit pair operations (MOVW, ADIW, SBIW). Each operation writes the low byte,
// then the high byte, then pulses done with the C/Z/N/V results.
// Every output is decoded from registered state and captured fields. The
// register-file read data is the only combinational input to the datapath.
module regpair_sequencer #(
    parameter int IMM_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [3:0]       dst,
    input  logic [3:0]       src,
    input  logic [IMM_W-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             rf_we,
    output logic [4:0]       rf_add1,
    output logic [4:0]       rf_add2,
    output logic [7:0]       rf_din1,
    input  logic [7:0]       rf_dout1,
    input  logic [7:0]       rf_dout2
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MOVW = 2'b00;
    localparam logic [1:0] OP_ADIW = 2'b01;
    localparam logic [1:0] OP_SBIW = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    logic [1:0]       state_reg, state_next;
    logic [1:0]       op_reg;
    logic [3:0]       dst_reg;
    logic [3:0]       src_reg;
    logic [IMM_W-1:0] imm_reg;
    logic             cy_reg;       // carry/borrow out of the low byte
    logic             lo_zero_reg;  // low result byte was zero
    logic             flag_c_reg, flag_z_reg, flag_n_reg, flag_v_reg;

    logic [7:0] imm8;
    logic [8:0] alu9;               // bit 8 is the carry/borrow out of this byte
    logic       is_arith;

    // The immediate is zero-extended to 16 bits. Its high byte is therefore
    // always zero, so only the low byte is needed here.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_imm_ext
            if (gi < IMM_W) begin : g_bit
                assign imm8[gi] = imm_reg[gi];
            end else begin : g_zero
                assign imm8[gi] = 1'b0;
            end
        end
    endgenerate

    assign is_arith = (op_reg == OP_ADIW) || (op_reg == OP_SBIW);

    // Next-state logic; a reserved opcode skips both write cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req) state_next = (op == OP_NOP) ? S_DONE : S_LO;
            S_LO:    state_next = S_HI;
            S_HI:    state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Byte ALU: the low byte uses the immediate, the high byte uses the saved carry.
    always_comb begin
        alu9 = 9'd0;
        if (state_reg == S_LO) begin
            case (op_reg)
                OP_ADIW: alu9 = {1'b0, rf_dout1} + {1'b0, imm8};
                OP_SBIW: alu9 = {1'b0, rf_dout1} - {1'b0, imm8};
                default: alu9 = {1'b0, rf_dout2};
            endcase
        end else if (state_reg == S_HI) begin
            case (op_reg)
                OP_ADIW: alu9 = {1'b0, rf_dout1} + {8'd0, cy_reg};
                OP_SBIW: alu9 = {1'b0, rf_dout1} - {8'd0, cy_reg};
                default: alu9 = {1'b0, rf_dout2};
            endcase
        end
    end

    // Moore decode of register-file controls and handshake outputs.
    always_comb begin
        rf_we   = 1'b0;
        rf_add1 = 5'd0;
        rf_add2 = 5'd0;
        rf_din1 = 8'd0;
        if (state_reg == S_LO) begin
            rf_we   = 1'b1;
            rf_add1 = {dst_reg, 1'b0};
            rf_add2 = {src_reg, 1'b0};
            rf_din1 = alu9[7:0];
        end else if (state_reg == S_HI) begin
            rf_we   = 1'b1;
            rf_add1 = {dst_reg, 1'b1};
            rf_add2 = {src_reg, 1'b1};
            rf_din1 = alu9[7:0];
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign flag_c = flag_c_reg;
    assign flag_z = flag_z_reg;
    assign flag_n = flag_n_reg;
    assign flag_v = flag_v_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Capture the request fields on acceptance; they stay stable while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg  <= 2'd0;
            dst_reg <= 4'd0;
            src_reg <= 4'd0;
            imm_reg <= '0;
        end else if (state_reg == S_IDLE && req) begin
            op_reg  <= op;
            dst_reg <= dst;
            src_reg <= src;
            imm_reg <= imm;
        end
    end

    // Keep the low-byte carry and zero status for the high-byte cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cy_reg      <= 1'b0;
            lo_zero_reg <= 1'b0;
        end else if (state_reg == S_LO) begin
            cy_reg      <= alu9[8];
            lo_zero_reg <= (alu9[7:0] == 8'd0);
        end
    end

    // Flags update at the end of the high-byte cycle, for ADIW/SBIW only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_c_reg <= 1'b0;
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_v_reg <= 1'b0;
        end else if (state_reg == S_HI && is_arith) begin
            flag_c_reg <= alu9[8];
            flag_z_reg <= lo_zero_reg && (alu9[7:0] == 8'd0);
            flag_n_reg <= alu9[7];
            flag_v_reg <= (op_reg == OP_ADIW) ? (~rf_dout1[7] & alu9[7])
                                              : (rf_dout1[7] & ~alu9[7]);
        end
    end

endmodule

// File: tb/tb_regpair_sequencer.sv
// Testbench for regpair_sequencer: a behavioural 32x8 register file around the
// DUT, a table of directed pair operations, plus hand-written sequences for
// back-to-back requests and asynchronous reset during the high-byte write.
module tb_regpair_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [1:0] op;
    logic [3:0] dst;
    logic [3:0] src;
    logic [5:0] imm;
    logic       busy, done, flag_c, flag_z, flag_n, flag_v, rf_we;
    logic [4:0] rf_add1, rf_add2;
    logic [7:0] rf_din1, rf_dout1, rf_dout2;

    // Register file model with preset port.
    logic [7:0]  rf [32];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_pair = 4'd0;
    logic [15:0] pre_val = 16'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regpair_sequencer #(.IMM_W(6)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .dst(dst), .src(src),
        .imm(imm), .busy(busy), .done(done), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v), .rf_we(rf_we), .rf_add1(rf_add1),
        .rf_add2(rf_add2), .rf_din1(rf_din1), .rf_dout1(rf_dout1),
        .rf_dout2(rf_dout2)
    );

    assign rf_dout1 = rf[rf_add1];
    assign rf_dout2 = rf[rf_add2];

    always @(posedge clk) begin
        if (rf_we) rf[rf_add1] <= rf_din1;
        if (pre_we) begin
            rf[{pre_pair, 1'b0}] <= pre_val[7:0];
            rf[{pre_pair, 1'b1}] <= pre_val[15:8];
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [5:0]  imm;
        logic [15:0] dst_init;
        logic [15:0] src_init;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;   // {C,Z,N,V}
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic [1:0] o, logic [3:0] d, logic [3:0] s,
                                logic [5:0] i, logic [15:0] di, logic [15:0] si,
                                logic [15:0] er, logic [3:0] ef, int el, int ew);
        vec_t v;
        v.op = o; v.dst = d; v.src = s; v.imm = i; v.dst_init = di;
        v.src_init = si; v.exp_res = er; v.exp_flags = ef; v.exp_lat = el;
        v.exp_we = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pair_val(logic [3:0] p);
        return {rf[{p, 1'b1}], rf[{p, 1'b0}]};
    endfunction

    task automatic preset16(input logic [3:0] p, input logic [15:0] v);
        @(negedge clk);
        pre_pair = p; pre_val = v; pre_we = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, wes;
        bit got;
        preset16(v.dst, v.dst_init);
        if (v.op == 2'b00) preset16(v.src, v.src_init);
        @(negedge clk);
        op = v.op; dst = v.dst; src = v.src; imm = v.imm; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; wes = 0; got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (rf_we) wes++;
            if (done) begin got = 1'b1; lat = c; end
        end
        chk($sformatf("v%0d done_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d we_cycles", idx), wes, v.exp_we);
        chk($sformatf("v%0d result", idx), pair_val(v.dst), v.exp_res);
        chk($sformatf("v%0d flags_czn_v", idx), {flag_c, flag_z, flag_n, flag_v}, v.exp_flags);
        $display("vec %0d op=%0d dst=%0d src=%0d imm=%0d init=%04h -> res=%04h flags=%b lat=%0d",
                 idx, v.op, v.dst, v.src, v.imm, v.dst_init, pair_val(v.dst),
                 {flag_c, flag_z, flag_n, flag_v}, lat);
    endtask

    initial begin
        int n_done, n_we, n_busy;

        //            op     dst   src   imm   dst_init  src_init  exp_res   CZNV   lat we
        vecs[0] = mk(2'b01, 4'd12, 4'd12, 6'd1,  16'h00FF, 16'h0000, 16'h0100, 4'b0000, 3, 2);
        vecs[1] = mk(2'b10, 4'd13, 4'd13, 6'd1,  16'h0000, 16'h0000, 16'hFFFF, 4'b1010, 3, 2);
        vecs[2] = mk(2'b01, 4'd12, 4'd12, 6'd63, 16'hFFC1, 16'h0000, 16'h0000, 4'b1100, 3, 2);
        vecs[3] = mk(2'b00, 4'd0,  4'd15, 6'd0,  16'h5555, 16'hBEEF, 16'hBEEF, 4'b1100, 3, 2);
        vecs[4] = mk(2'b01, 4'd14, 4'd14, 6'd1,  16'h7FFF, 16'h0000, 16'h8000, 4'b0011, 3, 2);
        vecs[5] = mk(2'b10, 4'd15, 4'd15, 6'd1,  16'h8000, 16'h0000, 16'h7FFF, 4'b0001, 3, 2);
        vecs[6] = mk(2'b11, 4'd3,  4'd3,  6'd9,  16'h1234, 16'h0000, 16'h1234, 4'b0001, 1, 0);
        vecs[7] = mk(2'b10, 4'd1,  4'd1,  6'h20, 16'h0100, 16'h0000, 16'h00E0, 4'b0000, 3, 2);
        vecs[8] = mk(2'b00, 4'd5,  4'd5,  6'd0,  16'hA55A, 16'hA55A, 16'hA55A, 4'b0000, 3, 2);
        vecs[9] = mk(2'b01, 4'd6,  4'd6,  6'd2,  16'hFFFE, 16'h0000, 16'h0000, 4'b1100, 3, 2);

        reset = 1'b1; req = 1'b0; op = 2'b00; dst = 4'd0; src = 4'd0; imm = 6'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_add1", rf_add1, 0);
        chk("reset rf_add2", rf_add2, 0);
        chk("reset rf_din1", rf_din1, 0);
        chk("reset flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // req held high: one op every 4 cycles, two write cycles each.
        preset16(4'd2, 16'h0000);
        @(negedge clk);
        op = 2'b01; dst = 4'd2; src = 4'd2; imm = 6'd1; req = 1'b1;
        @(posedge clk);
        n_done = 0; n_we = 0; n_busy = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done)  n_done++;
            if (rf_we) n_we++;
            if (busy)  n_busy++;
        end
        req = 1'b0;
        chk("hold done_count", n_done, 4);
        chk("hold we_count", n_we, 8);
        chk("hold busy_count", n_busy, 12);
        chk("hold result", pair_val(4'd2), 16'h0004);
        $display("hold: done=%0d we=%0d busy=%0d res=%04h", n_done, n_we, n_busy, pair_val(4'd2));

        // Asynchronous reset in the middle of the high-byte cycle.
        preset16(4'd4, 16'h00FF);
        @(negedge clk);
        op = 2'b01; dst = 4'd4; src = 4'd4; imm = 6'd1; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);             // now in HI
        #1 chk("pre-reset rf_we in HI", rf_we, 1);
        #1 reset = 1'b1;
        #1;
        chk("async reset rf_we", rf_we, 0);
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        chk("async reset rf_add1", rf_add1, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("half-written low byte", rf[5'd8], 8'h00);
        chk("half-written high byte", rf[5'd9], 8'h00);
        $display("reset-in-HI: r9:r8=%04h busy=%0d", pair_val(4'd4), busy);

        run_vec(10, mk(2'b01, 4'd4, 4'd4, 6'd1, 16'h00FF, 16'h0000, 16'h0100, 4'b0000, 3, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
